// File: rtl/audio_capture_ctrl_if.sv
// audio_capture_ctrl_if: Avalon-MM register bus between a host and audio_capture_ctrl.
interface audio_capture_ctrl_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/audio_capture_ctrl.sv
// audio_capture_ctrl: I2S stereo capture into a frame FIFO behind an Avalon-MM register file.
// Define AUDIO_CAPTURE_IRQ_EN to enable the threshold/overflow interrupt and THRESH register.
module audio_capture_ctrl #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  audio_capture_ctrl_if.slave  bus,
  input  logic                 aud_bclk,
  input  logic                 aud_lrck,
  input  logic                 aud_dat,
  output logic                 irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, WAIT_L, SKIP, SHIFT, NEXT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          bclk_q, lrck_q;
  logic [1:0]          dat_q;
  logic [SAMPLE_W-1:0] sh_q, sh_d, left_q, left_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                ch_q, ch_d, lok_q, lok_d, push_req;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wp_q, rp_q;
  logic [CW-1:0]       count_q;
  logic                ovf_q, enable_q;
  logic [31:0]         readdata_q, rd_mux, frame;
  logic                bclk_rise, lrck_rise, lrck_fall, empty, full, pop, push, flush, irq_en_rd;
  logic [6:0]          thresh_rd;

  // Third stage of each clock synchronizer only remembers the previous level for edge detection
  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lrck_rise = lrck_q[1] & ~lrck_q[2];
  assign lrck_fall = ~lrck_q[1] & lrck_q[2];
  assign frame     = {16'(left_q), 16'(sh_q)};
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign pop       = bus.read && bus.address == 2'd0 && !empty;
  assign flush     = bus.write && bus.address == 2'd2 && bus.writedata[2];
  assign push      = push_req && (!full || pop) && !flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    left_d   = left_q;
    ch_d     = ch_q;
    lok_d    = lok_q;
    push_req = 1'b0;
    case (state_q)
      IDLE:   if (enable_q) state_d = WAIT_L;
      WAIT_L: if (lrck_fall) begin
        state_d = SKIP;
        ch_d    = 1'b0;
        lok_d   = 1'b0;
      end
      SKIP, SHIFT: if (lrck_rise || lrck_fall) begin
        state_d = SKIP;
        ch_d    = lrck_rise;
        lok_d   = 1'b0;
      end else if (bclk_rise) begin
        if (state_q == SKIP) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          sh_d  = {sh_q[SAMPLE_W-2:0], dat_q[1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(SAMPLE_W - 1)) begin
            state_d = NEXT;
            left_d  = ch_q ? left_q : sh_d;
          end
        end
      end
      NEXT: if (lrck_rise) begin
        state_d = SKIP;
        lok_d   = !ch_q;
        ch_d    = 1'b1;
      end else if (lrck_fall) begin
        state_d  = SKIP;
        push_req = ch_q && lok_q;
        ch_d     = 1'b0;
        lok_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (!enable_q) state_d = IDLE;
  end

  assign rd_mux = bus.address == 2'd0 ? (empty ? 32'd0 : mem[rp_q]) :
                  bus.address == 2'd1 ? {8'd0, 8'(count_q), 13'd0, ovf_q, full, empty} :
                  bus.address == 2'd2 ? {30'd0, irq_en_rd, enable_q} :
                                        {25'd0, thresh_rd};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_q     <= '0;
      lrck_q     <= '0;
      dat_q      <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      left_q     <= '0;
      ch_q       <= 1'b0;
      lok_q      <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      enable_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      bclk_q  <= {bclk_q[1:0], aud_bclk};
      lrck_q  <= {lrck_q[1:0], aud_lrck};
      dat_q   <= {dat_q[0], aud_dat};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      left_q  <= left_d;
      ch_q    <= ch_d;
      lok_q   <= lok_d;
      if (flush) begin
        wp_q    <= '0;
        rp_q    <= '0;
        count_q <= '0;
      end else begin
        wp_q    <= push ? wp_q + AW'(1) : wp_q;
        rp_q    <= pop ? rp_q + AW'(1) : rp_q;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
      ovf_q      <= (push_req && full && !pop && !flush) ? 1'b1 :
                    (bus.write && bus.address == 2'd1 && bus.writedata[2]) ? 1'b0 : ovf_q;
      enable_q   <= (bus.write && bus.address == 2'd2) ? bus.writedata[0] : enable_q;
      readdata_q <= bus.read ? rd_mux : readdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= frame;
  end

  assign bus.readdata = readdata_q;

`ifdef AUDIO_CAPTURE_IRQ_EN
  logic       irq_en_q, irq_q;
  logic [6:0] thresh_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= (bus.write && bus.address == 2'd2) ? bus.writedata[1] : irq_en_q;
      thresh_q <= (bus.write && bus.address == 2'd3) ? bus.writedata[6:0] : thresh_q;
      irq_q    <= irq_en_q && ((8'(count_q) >= {1'b0, thresh_q} && thresh_q != '0) || ovf_q);
    end
  end
  assign irq_en_rd = irq_en_q;
  assign thresh_rd = thresh_q;
  assign irq       = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign thresh_rd = '0;
  assign irq       = 1'b0;
`endif
endmodule

// File: tb/tb_audio_capture_ctrl.sv
// tb_audio_capture_ctrl: directed I2S frames and register accesses against hand-computed values.
module tb_audio_capture_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic aud_bclk = 1'b1, aud_lrck = 1'b1, aud_dat = 1'b0;
  logic irq;
  logic [31:0] d;
  int checks = 0, errors = 0;

  audio_capture_ctrl_if bus ();
  audio_capture_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave), .aud_bclk(aud_bclk),
                          .aud_lrck(aud_lrck), .aud_dat(aud_dat), .irq(irq));

  always #5 clk = ~clk;

`ifdef AUDIO_CAPTURE_IRQ_EN
  localparam logic [31:0] CTRL3_EXP = 32'd3, THRESH5_EXP = 32'd5;
`else
  localparam logic [31:0] CTRL3_EXP = 32'd1, THRESH5_EXP = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.address = a; bus.writedata = v; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    v = bus.readdata;
  endtask

  task automatic i2s_bit(input logic b);
    aud_bclk = 1'b0; aud_dat = b; #40;
    aud_bclk = 1'b1; #40;
  endtask

  // One delay bit, n data bits MSB first, then pad idle bits
  task automatic chan(input logic [15:0] v, input int n, input int pad);
    i2s_bit(1'b0);
    for (int i = 15; i > 15 - n; i--) i2s_bit(v[i]);
    for (int i = 0; i < pad; i++) i2s_bit(1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    aud_lrck = 1'b0; chan(l, 16, 3);
    aud_lrck = 1'b1; chan(r, 16, 3);
  endtask

  task automatic close_frame();
    aud_lrck = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    #23;
    chk("reset_readdata", bus.readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    rd(2'd1, d); chk("status_reset", d, 32'h1);
    rd(2'd0, d); chk("data_empty", d, 32'h0);
    rd(2'd1, d); chk("status_after_empty_read", d, 32'h1);
    wr(2'd2, 32'h3);
    rd(2'd2, d); chk("ctrl_rd", d, CTRL3_EXP);
    wr(2'd3, 32'hFFFF_FF85);
    rd(2'd3, d); chk("thresh_rd", d, THRESH5_EXP);
    wr(2'd3, 32'h0);

    send_frame(16'hA5C3, 16'h1234); close_frame();
    rd(2'd1, d); chk("one_frame_status", d, 32'h0001_0000);
    rd(2'd0, d); chk("one_frame_data", d, 32'hA5C3_1234);
    rd(2'd1, d); chk("one_frame_empty", d, 32'h1);

    chan(16'hFFFF, 9, 0);
    aud_lrck = 1'b1; chan(16'h5555, 16, 3);
    send_frame(16'h0F0F, 16'hF0F0); close_frame();
    rd(2'd1, d); chk("short_status", d, 32'h0001_0000);
    rd(2'd0, d); chk("short_next_data", d, 32'h0F0F_F0F0);

    for (int i = 1; i <= 17; i++) send_frame(16'h1100 + 16'(i), 16'h2200 + 16'(i));
    close_frame();
    rd(2'd1, d); chk("full_status", d, 32'h0010_0006);
    for (int i = 1; i <= 16; i++) begin
      rd(2'd0, d);
      chk($sformatf("full_data_%0d", i), d, {16'h1100 + 16'(i), 16'h2200 + 16'(i)});
    end
    rd(2'd1, d); chk("drained_status", d, 32'h5);
    wr(2'd1, 32'h4);
    rd(2'd1, d); chk("ovf_clear", d, 32'h1);

    send_frame(16'hBEEF, 16'hCAFE); close_frame();
    chan(16'h1111, 16, 3);
    aud_lrck = 1'b1; chan(16'h2222, 8, 0);
    wr(2'd2, 32'h0);
    aud_lrck = 1'b0; chan(16'h3333, 16, 3);
    repeat (10) @(negedge clk);
    rd(2'd1, d); chk("disable_keeps_fifo", d, 32'h0001_0000);
    rd(2'd0, d); chk("disable_data", d, 32'hBEEF_CAFE);

    aud_lrck = 1'b1; repeat (10) @(negedge clk);
    wr(2'd2, 32'h3);
    wr(2'd3, 32'h3);
    for (int i = 1; i <= 3; i++) send_frame(16'h3300 + 16'(i), 16'h4400 + 16'(i));
    close_frame();
    repeat (3) @(negedge clk);
`ifdef AUDIO_CAPTURE_IRQ_EN
    chk("irq_at_thresh", {31'd0, irq}, 32'd1);
`else
    chk("irq_tied_low", {31'd0, irq}, 32'd0);
`endif
    rd(2'd0, d); chk("thr_data_1", d, 32'h3301_4401);
    repeat (3) @(negedge clk);
    chk("irq_below_thresh", {31'd0, irq}, 32'd0);
    rd(2'd0, d); chk("thr_data_2", d, 32'h3302_4402);
    rd(2'd0, d); chk("thr_data_3", d, 32'h3303_4403);

    send_frame(16'h7777, 16'h8888);
    @(negedge clk);
    bus.address = 2'd2; bus.writedata = 32'h5; bus.write = 1'b1;
    #2 aud_lrck = 1'b0;
    repeat (6) @(negedge clk);
    bus.write = 1'b0;
    repeat (5) @(negedge clk);
    rd(2'd1, d); chk("flush_wins", d, 32'h1);

    chan(16'hFFFF, 5, 0);
    rd(2'd1, d);
    #3 reset_n = 1'b0;
    #1;
    chk("midshift_reset_readdata", bus.readdata, 32'd0);
    chk("midshift_reset_irq", {31'd0, irq}, 32'd0);
    #50 reset_n = 1'b1;
    aud_lrck = 1'b1; repeat (10) @(negedge clk);
    rd(2'd1, d); chk("post_reset_status", d, 32'h1);
    wr(2'd2, 32'h1);
    send_frame(16'h9ABC, 16'hDEF0); close_frame();
    rd(2'd1, d); chk("post_reset_count", d, 32'h0001_0000);
    rd(2'd0, d); chk("post_reset_data", d, 32'h9ABC_DEF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
